bpu_update_sched: RTL

// - Schedules branch-resolution outcomes onto the single BPU update port (update_valid/addr/taken).
// - Sits between the execute-stage resolution ports and the BPU. Arbitrates NREQ requesters round-robin.
// - Buffers accepted outcomes in a DEPTH-entry FIFO and issues at most one update per cycle.
// - Supports a hold (suppress issue) and a flush (discard wrong-path outcomes).

---
 rtl/bpu_pkg.sv | 16 +
 rtl/bpu_update_sched_if.sv | 31 +++
 rtl/bpu_upd_fifo.sv | 48 ++++
 rtl/bpu_update_sched.sv | 124 ++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and helpers for the BPU update scheduler: the queued update
// record and the round-robin pointer advance.
package bpu_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        taken;
    } bpu_upd_t;

    localparam int BPU_IDX_BITS = 10;

    function automatic int rr_next(input int g, input int n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/bpu_update_sched_if.sv
// Bundle of resolution-request, control and BPU-update signals around the
// scheduler; the DUT side uses the slave modport.
interface bpu_update_sched_if #(
    parameter int NREQ  = 2,
    parameter int DEPTH = 4
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][31:0]      req_addr;
    logic [NREQ-1:0]            req_taken;
    logic [NREQ-1:0]            req_ready;
    logic                       flush;
    logic                       hold;
    logic                       upd_valid;
    logic [31:0]                upd_addr;
    logic                       upd_taken;
    logic [$clog2(DEPTH):0]     q_count;
    logic [31:0]                stat_issued;
    logic [31:0]                stat_full_cyc;

    modport master (
        output req_valid, req_addr, req_taken, flush, hold,
        input  req_ready, upd_valid, upd_addr, upd_taken, q_count,
               stat_issued, stat_full_cyc
    );

    modport slave (
        input  req_valid, req_addr, req_taken, flush, hold,
        output req_ready, upd_valid, upd_addr, upd_taken, q_count,
               stat_issued, stat_full_cyc
    );
endinterface

// File: rtl/bpu_upd_fifo.sv
// DEPTH-entry FIFO of BPU update records. Pointers carry one extra wrap bit so
// full and empty are told apart by the MSB compare.
module bpu_upd_fifo
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  bpu_upd_t      i_data,
    output bpu_upd_t      o_head,
    output logic [PW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);
    bpu_upd_t        r_mem [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;

    // read/write pointers; flush returns both to empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PW'(1);
            if (i_pop)  r_rd <= r_rd + PW'(1);
        end
    end

    // storage array, deliberately unreset
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_data;
    end

    assign o_head  = r_mem[r_rd[AW-1:0]];
    assign o_count = r_wr - r_rd;
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
endmodule

// File: rtl/bpu_update_sched.sv
// Round-robin scheduler of branch outcomes onto the single BPU update port.
// Optional statistics counters are built when BPU_UPD_STATS_EN is defined.
module bpu_update_sched
    import bpu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DEPTH = 4,
    localparam int RRW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int PW   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    bpu_update_sched_if.slave bus
);
    logic [RRW-1:0]  r_rr;
    logic [RRW-1:0]  w_scan;
    logic [RRW-1:0]  w_gnt_idx;
    logic            w_gnt_any;
    logic [NREQ-1:0] w_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic [PW-1:0]   w_count;
    bpu_upd_t        w_push_data;
    bpu_upd_t        w_head;
    logic            r_upd_valid;
    bpu_upd_t        r_upd;

    // first valid requester at or after the round-robin pointer
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = RRW'((int'(r_rr) + k) % NREQ);
            if (!w_gnt_any && bus.req_valid[w_scan]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan;
            end else begin
                w_gnt_any = w_gnt_any;
            end
        end
    end

    // a full queue refuses even if a pop is due this cycle
    always_comb begin
        w_ready = '0;
        if (w_gnt_any && !w_full && !bus.flush) begin
            w_ready[w_gnt_idx] = 1'b1;
        end else begin
            w_ready = '0;
        end
    end

    assign bus.req_ready    = w_ready;
    assign w_push           = |w_ready;
    assign w_pop            = !w_empty && !bus.hold && !bus.flush;
    assign w_push_data.addr = bus.req_addr[w_gnt_idx];
    assign w_push_data.taken = bus.req_taken[w_gnt_idx];

    bpu_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.flush),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // round-robin pointer advances only on an accepted transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= '0;
        end else if (w_push) begin
            r_rr <= RRW'(rr_next(int'(w_gnt_idx), NREQ));
        end
    end

    // issue register: address/direction hold their last value when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upd_valid <= 1'b0;
            r_upd       <= '0;
        end else if (w_pop) begin
            r_upd_valid <= 1'b1;
            r_upd       <= w_head;
        end else begin
            r_upd_valid <= 1'b0;
        end
    end

    assign bus.upd_valid = r_upd_valid;
    assign bus.upd_addr  = r_upd.addr;
    assign bus.upd_taken = r_upd.taken;
    assign bus.q_count   = w_count;

`ifdef BPU_UPD_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_full_cyc;

    // free-running statistics, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_issued   <= 32'd0;
            r_stat_full_cyc <= 32'd0;
        end else begin
            if (w_pop) r_stat_issued <= r_stat_issued + 32'd1;
            if ((|bus.req_valid) && w_full && !bus.flush)
                r_stat_full_cyc <= r_stat_full_cyc + 32'd1;
        end
    end

    assign bus.stat_issued   = r_stat_issued;
    assign bus.stat_full_cyc = r_stat_full_cyc;
`else
    assign bus.stat_issued   = 32'd0;
    assign bus.stat_full_cyc = 32'd0;
`endif
endmodule
